// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and default width.
package serial_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/OneBitFullAdder.sv
// Single-bit full adder used as the per-bit add stage of the serial adder.
module OneBitFullAdder (
  input  logic A1,
  input  logic B1,
  input  logic CI,
  output logic S1,
  output logic CO
);

  assign S1 = A1 ^ B1 ^ CI;
  assign CO = (A1 & B1) | (CI & (A1 ^ B1));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: processes one operand bit per clock, LSB first, through a
// single full adder; sum shifts in from the MSB side.
module serial_adder
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned     CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic             cout_q;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_co;
  logic             last_bit;

  assign last_bit = (cnt == LAST);

  OneBitFullAdder u_fa (
    .A1 (a_sh[0]),
    .B1 (b_sh[0]),
    .CI (carry),
    .S1 (fa_s),
    .CO (fa_co)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: status decoded from the state register, results from their registers
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    sum  = sum_sh;
    cout = cout_q;
    case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath; cout is only written on the last bit so partial carries stay hidden
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            carry  <= cin;
            sum_sh <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          carry  <= fa_co;
          cnt    <= cnt + CNT_W'(1);
          if (last_bit) cout_q <= fa_co;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=4.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       cin8 = 1'b0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  logic       start4 = 1'b0;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic       cin4 = 1'b0;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  // Stimulus helper (no checking). Call just after a negedge; returns just after a negedge.
  // lat counts negedges after the accepting edge until done is seen (0 = timeout).
  task automatic do_op8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                        output int lat, output int nbusy, output logic [7:0] s,
                        output logic c, output logic pulse_ok, output logic stable);
    logic c0;
    c0 = cout8;
    a8 = ia; b8 = ib; cin8 = ic; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0; nbusy = 0; stable = 1'b1; s = '0; c = 1'b0; pulse_ok = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done8) begin
        lat = i; s = sum8; c = cout8;
        break;
      end
      if (busy8) nbusy++;
      if (cout8 !== c0) stable = 1'b0;
      // scramble inputs while running; none of this may leak into the result
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); start8 = 1'($urandom);
    end
    start8 = 1'b0;
    @(negedge clk);
    pulse_ok = (done8 === 1'b0) && (busy8 === 1'b0) && (sum8 === s) && (cout8 === c);
  endtask

  task automatic do_op4(input logic [3:0] ia, input logic [3:0] ib, input logic ic,
                        output int lat, output logic [3:0] s, output logic c,
                        output logic pulse_ok);
    a4 = ia; b4 = ib; cin4 = ic; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    lat = 0; s = '0; c = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done4) begin
        lat = i; s = sum4; c = cout4;
        break;
      end
    end
    @(negedge clk);
    pulse_ok = (done4 === 1'b0);
  endtask

  task automatic check_op8(input string name, input logic [7:0] ia, input logic [7:0] ib,
                           input logic ic);
    int lat, nbusy;
    logic [7:0] s;
    logic c, pulse_ok, stable;
    logic [8:0] exp;
    exp = 9'(ia) + 9'(ib) + 9'(ic);
    do_op8(ia, ib, ic, lat, nbusy, s, c, pulse_ok, stable);
    vectors++;
    if ({c, s} !== exp) begin
      miscompares++;
      $display("FAIL %s result a=%h b=%h cin=%b: got %h, expected %h", name, ia, ib, ic, {c, s}, exp);
    end
    vectors++;
    if (lat !== 9) begin
      miscompares++;
      $display("FAIL %s latency: got %0d, expected 9", name, lat);
    end
    vectors++;
    if (nbusy !== 8) begin
      miscompares++;
      $display("FAIL %s busy cycles: got %0d, expected 8", name, nbusy);
    end
    vectors++;
    if (pulse_ok !== 1'b1) begin
      miscompares++;
      $display("FAIL %s done pulse/hold: got %b, expected 1", name, pulse_ok);
    end
    vectors++;
    if (stable !== 1'b1) begin
      miscompares++;
      $display("FAIL %s cout changed mid-run: got %b, expected 1", name, stable);
    end
  endtask

  task automatic test_reset;
    int lat, nbusy;
    logic [7:0] s;
    logic c, pulse_ok, stable;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({busy8, done8, sum8, cout8, busy4, done4, sum4, cout4} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got %b, expected all zero",
               {busy8, done8, sum8, cout8, busy4, done4, sum4, cout4});
    end
    rst = 1'b0;
    // start on the very first edge after reset release must be accepted
    do_op8(8'h12, 8'h34, 1'b0, lat, nbusy, s, c, pulse_ok, stable);
    vectors++;
    if (lat !== 9 || {c, s} !== 9'h046) begin
      miscompares++;
      $display("FAIL reset_first_start: got lat=%0d res=%h, expected lat=9 res=046", lat, {c, s});
    end
  endtask

  task automatic test_directed;
    check_op8("ff_plus_01", 8'hFF, 8'h01, 1'b0);
    check_op8("5a_a5_cin1", 8'h5A, 8'hA5, 1'b1);
    check_op8("5a_a5_cin0", 8'h5A, 8'hA5, 1'b0);
    check_op8("zero", 8'h00, 8'h00, 1'b0);
    check_op8("ff_ff_cin1", 8'hFF, 8'hFF, 1'b1);
  endtask

  task automatic test_random;
    for (int n = 0; n < 40; n++)
      check_op8("random", 8'($urandom), 8'($urandom), 1'($urandom));
  endtask

  task automatic test_start_held;
    int dones = 0;
    int last_done = 0;
    a8 = 8'h03; b8 = 8'h04; cin8 = 1'b0; start8 = 1'b1;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      if (done8) begin
        dones++;
        vectors++;
        if (sum8 !== 8'h07 || cout8 !== 1'b0) begin
          miscompares++;
          $display("FAIL held_start result: got %h/%b, expected 07/0", sum8, cout8);
        end
        if (last_done != 0) begin
          vectors++;
          if (i - last_done !== 10) begin
            miscompares++;
            $display("FAIL held_start period: got %0d, expected 10", i - last_done);
          end
        end
        last_done = i;
        a8 = 8'h03; b8 = 8'h04;
      end else if (busy8) begin
        a8 = 8'($urandom); b8 = 8'($urandom);
      end
    end
    start8 = 1'b0;
    vectors++;
    if (dones < 4) begin
      miscompares++;
      $display("FAIL held_start done count: got %0d, expected at least 4", dones);
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_abort;
    int dones = 0;
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({busy8, done8, sum8, cout8} !== '0) begin
      miscompares++;
      $display("FAIL abort_state: got %b, expected all zero", {busy8, done8, sum8, cout8});
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done8 || busy8) dones++;
    end
    vectors++;
    if (dones !== 0) begin
      miscompares++;
      $display("FAIL abort_no_done: got %0d active cycles, expected 0", dones);
    end
  endtask

  task automatic test_exhaustive4;
    int lat;
    logic [3:0] s;
    logic c, pulse_ok;
    logic [4:0] exp;
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++) begin
          exp = 5'(ia) + 5'(ib) + 5'(ic);
          do_op4(4'(ia), 4'(ib), 1'(ic), lat, s, c, pulse_ok);
          vectors++;
          if ({c, s} !== exp || lat !== 5 || pulse_ok !== 1'b1) begin
            miscompares++;
            $display("FAIL w4 a=%0d b=%0d cin=%0d: got res=%h lat=%0d pulse=%b, expected res=%h lat=5 pulse=1",
                     ia, ib, ic, {c, s}, lat, pulse_ok, exp);
          end
        end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_start_held();
    test_abort();
    test_exhaustive4();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, 8, operand/sum width in bits (legal range 2..32).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  operand A, captured on accepted start.
REQ-006 Port: b  input  WIDTH  operand B, captured on accepted start.
REQ-007 Port: cin  input  1  carry-in, captured on accepted start.
REQ-008 Port: busy  output  1  high while bits are being processed (RUN).
REQ-009 Port: done  output  1  one-cycle pulse: sum/cout valid.
REQ-010 Port: sum  output  WIDTH  result bits, registered.
REQ-011 Port: cout  output  1  final carry-out, registered.
REQ-012 The block SHALL have one clock (clk) and a synchronous, active-high reset (rst).

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-014 IDLE: start=1 at an edge SHALL load a, b into shift registers, load carry register with cin, clear bit counter, clear sum register, go to RUN.
REQ-015 RUN: each edge SHALL add operand LSBs plus carry register in one full-adder, shift sum bit into sum MSB (sum shifts right), shift both operands right, store carry-out in carry register, increment counter.
REQ-016 RUN SHALL last exactly WIDTH edges, processing bits LSB-first; after the WIDTH-th edge state SHALL be DONE, sum = (a+b+cin) mod 2^WIDTH, cout = bit WIDTH of a+b+cin.
REQ-017 Latency: start accepted at edge k -> done high in the cycle after edge k+WIDTH, i.e. WIDTH+1 edges after acceptance.
REQ-018 DONE: done=1 for exactly one cycle; next edge SHALL return to IDLE unconditionally.
REQ-019 busy SHALL be 1 exactly in RUN; done exactly in DONE; both decoded from state register.
REQ-020 sum and cout SHALL hold their final values in DONE and IDLE until the next accepted start.
REQ-021 start in RUN or DONE SHALL be ignored (not queued); a, b, cin changing during RUN SHALL not affect the result.
REQ-022 cout SHALL be updated only on the final RUN edge; intermediate carries SHALL not be visible on cout.
REQ-023 Bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and never wrap during a valid operation.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE, busy=0, done=0, sum=0, cout=0, carry register=0, counter=0, operand registers=0.
REQ-025 rst SHALL take priority over start and over any in-flight RUN/DONE; an aborted operation SHALL produce no done pulse.
REQ-026 After rst deasserts, start on the first following edge SHALL be accepted.

Structure
REQ-027 The per-bit add SHALL be one instance of the team's OneBitFullAdder (inputs A1, B1, CI; outputs S1, CO); no other sub-module.
REQ-028 State encoding (IDLE/RUN/DONE) and default WIDTH SHALL live in shared package serial_pkg.
REQ-029 All outputs SHALL be driven directly from registers; no combinational path from inputs to outputs.

Verification
REQ-030 WIDTH=8, a=8'hFF, b=8'h01, cin=0, start pulse -> busy 8 cycles, done 9 edges after start, sum=8'h00, cout=1.
REQ-031 WIDTH=8, a=8'h5A, b=8'hA5, cin=1 -> sum=8'h00, cout=1; with cin=0 -> sum=8'hFF, cout=0.
REQ-032 Start held high continuously with a=8'h03, b=8'h04; change a/b mid-RUN -> sum=8'h07, one done per IDLE visit, next op begins edge after DONE->IDLE.
REQ-033 rst asserted at 4th RUN edge -> next cycle busy=0, done=0, sum=0, cout=0; no done pulse follows.
REQ-034 WIDTH=4 exhaustive: all 512 (a,b,cin) -> {cout,sum} == a+b+cin for each, done pulse width exactly 1 cycle.
